// File: rtl/mem_ctrl_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arbiter_pkg
//   Shared definitions for the MEM / I-cache memory controller: controller
//   state encoding, request owner, read/write encoding, busy/enable levels,
//   the reset level and the request-length saturation helper.
// -----------------------------------------------------------------------------
package mem_ctrl_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_MEM = 1'b0,
      OWN_IC  = 1'b1
   } owner_t;

   localparam logic RW_READ    = 1'b0;
   localparam logic RW_WRITE   = 1'b1;
   localparam logic BUSY       = 1'b1;
   localparam logic ENABLE     = 1'b1;
   localparam logic RST_ACTIVE = 1'b0;

   // Longest transfer, in bytes; also the fixed I-cache fetch length.
   localparam logic [2:0] MAX_LEN = 3'd4;

   // Requests longer than a word are clipped to a full word.
   function automatic logic [2:0] eff_len(input logic [2:0] len);
      return (len > MAX_LEN) ? MAX_LEN : len;
   endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// mem_ctrl_arbiter
//   Memory controller between the MEM stage / I-cache and a byte-wide
//   synchronous RAM. MEM wins arbitration over the I-cache; each accepted
//   access is serialised one byte per cycle and reads are reassembled into a
//   little-endian word returned with a one-cycle completion pulse.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   MEM_E_in/rw/addr/data/len   MEM request (len 0 = no request, >4 -> 4)
//   IC_E_in, IC_addr_in     I-cache fetch (4 bytes); dropping IC_E_in aborts
//   mem_din_in              RAM read byte, valid one cycle after mem_a_out
//   busyMEM_out/busyICache_out  current owner, acceptance+1 .. DONE
//   MEM_dataE_out/MEM_data_out  MEM completion pulse and zero-extended load
//   IC_instE_out/IC_inst_out    fetch completion pulse and instruction
//   mem_a_out/mem_dout_out/mem_wr_out  RAM address, write byte, write enable
// -----------------------------------------------------------------------------
module mem_ctrl_arbiter
   import mem_ctrl_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  MEM_E_in,
   input  logic                  MEM_rw_in,
   input  logic [ADDR_WIDTH-1:0] MEM_addr_in,
   input  logic [DATA_WIDTH-1:0] MEM_data_in,
   input  logic [2:0]            MEM_len_in,
   input  logic                  IC_E_in,
   input  logic [ADDR_WIDTH-1:0] IC_addr_in,
   input  logic [7:0]            mem_din_in,
   output logic                  busyICache_out,
   output logic                  busyMEM_out,
   output logic                  MEM_dataE_out,
   output logic [DATA_WIDTH-1:0] MEM_data_out,
   output logic                  IC_instE_out,
   output logic [DATA_WIDTH-1:0] IC_inst_out,
   output logic [ADDR_WIDTH-1:0] mem_a_out,
   output logic [7:0]            mem_dout_out,
   output logic                  mem_wr_out
);

   state_t                state;
   owner_t                owner;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rbuf;
   logic [2:0]            len_q;
   // Cycle number within the active transfer: 1 in the first cycle after
   // acceptance. In READ, cycle k issues byte k-1 and captures byte k-2.
   logic [2:0]            cnt;

   logic                  mem_req;
   logic [2:0]            mem_len;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [1:0]            cap_idx;
   logic [7:0]            wr_byte;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  ic_abort;

   assign mem_req   = MEM_E_in && (MEM_len_in != 3'd0);
   assign mem_len   = eff_len(MEM_len_in);
   // Wraps modulo 2^ADDR_WIDTH by construction.
   assign next_addr = addr_q + ADDR_WIDTH'(cnt);
   assign wr_byte   = wdata_q[{cnt[1:0], 3'b000} +: 8];
   // Byte arriving in cycle k belongs to the address issued in cycle k-1.
   assign cap_idx   = cnt[1:0] - 2'd2;
   assign rd_word   = rbuf | (DATA_WIDTH'(mem_din_in) << {cap_idx, 3'b000});
   assign ic_abort  = (owner == OWN_IC) && !IC_E_in;

   // NOTE: every register, datapath included, is cleared by the async reset so
   // all outputs read 0 the instant rst_in falls and a cut transfer leaves no
   // stale word or pulse behind.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (rst_in == RST_ACTIVE) begin
         state          <= ST_IDLE;
         owner          <= OWN_MEM;
         addr_q         <= '0;
         wdata_q        <= '0;
         rbuf           <= '0;
         len_q          <= '0;
         cnt            <= '0;
         busyICache_out <= 1'b0;
         busyMEM_out    <= 1'b0;
         MEM_dataE_out  <= 1'b0;
         MEM_data_out   <= '0;
         IC_instE_out   <= 1'b0;
         IC_inst_out    <= '0;
         mem_a_out      <= '0;
         mem_dout_out   <= '0;
         mem_wr_out     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below sees
         // the register values from before this edge regardless of order.
         MEM_dataE_out <= 1'b0;
         IC_instE_out  <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               rbuf <= '0;
               cnt  <= 3'd1;
               if (mem_req) begin
                  owner        <= OWN_MEM;
                  addr_q       <= MEM_addr_in;
                  wdata_q      <= MEM_data_in;
                  len_q        <= mem_len;
                  busyMEM_out  <= BUSY;
                  mem_a_out    <= MEM_addr_in;
                  if (MEM_rw_in == RW_WRITE) begin
                     state        <= ST_WRITE;
                     mem_dout_out <= MEM_data_in[7:0];
                     mem_wr_out   <= ENABLE;
                  end else begin
                     state <= ST_READ;
                  end
               end else if (IC_E_in) begin
                  owner          <= OWN_IC;
                  addr_q         <= IC_addr_in;
                  len_q          <= MAX_LEN;
                  busyICache_out <= BUSY;
                  mem_a_out      <= IC_addr_in;
                  state          <= ST_READ;
               end
            end

            ST_READ: begin
               if (ic_abort) begin
                  state          <= ST_IDLE;
                  busyICache_out <= 1'b0;
                  mem_a_out      <= '0;
               end else begin
                  cnt <= cnt + 3'd1;
                  if (cnt >= 3'd2) begin
                     rbuf <= rd_word;
                  end
                  mem_a_out <= (cnt < len_q) ? next_addr : '0;
                  // Last byte arrives one cycle after the last address.
                  if (cnt == len_q + 3'd1) begin
                     state <= ST_DONE;
                     if (owner == OWN_IC) begin
                        IC_instE_out <= ENABLE;
                        IC_inst_out  <= rd_word;
                     end else begin
                        MEM_dataE_out <= ENABLE;
                        MEM_data_out  <= rd_word;
                     end
                  end
               end
            end

            ST_WRITE: begin
               if (cnt < len_q) begin
                  cnt          <= cnt + 3'd1;
                  mem_a_out    <= next_addr;
                  mem_dout_out <= wr_byte;
               end else begin
                  state         <= ST_DONE;
                  mem_a_out     <= '0;
                  mem_dout_out  <= '0;
                  mem_wr_out    <= 1'b0;
                  MEM_dataE_out <= ENABLE;
                  MEM_data_out  <= '0;
               end
            end

            ST_DONE: begin
               // No acceptance here: a requester still holding its enable
               // during the pulse cycle must not be restarted.
               state          <= ST_IDLE;
               busyICache_out <= 1'b0;
               busyMEM_out    <= 1'b0;
               MEM_data_out   <= '0;
               IC_inst_out    <= '0;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model predicts, from the acceptance cycle and the request, every
//   output of every cycle; a byte-wide RAM model answers the DUT's port.
// -----------------------------------------------------------------------------
module tb_mem_ctrl_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk_in      = 1'b0;
   logic          rst_in      = 1'b0;
   logic          MEM_E_in    = 1'b0;
   logic          MEM_rw_in   = 1'b0;
   logic [AW-1:0] MEM_addr_in = '0;
   logic [DW-1:0] MEM_data_in = '0;
   logic [2:0]    MEM_len_in  = '0;
   logic          IC_E_in     = 1'b0;
   logic [AW-1:0] IC_addr_in  = '0;
   logic [7:0]    mem_din_in  = '0;

   logic          busyICache_out;
   logic          busyMEM_out;
   logic          MEM_dataE_out;
   logic [DW-1:0] MEM_data_out;
   logic          IC_instE_out;
   logic [DW-1:0] IC_inst_out;
   logic [AW-1:0] mem_a_out;
   logic [7:0]    mem_dout_out;
   logic          mem_wr_out;

   mem_ctrl_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .MEM_E_in      (MEM_E_in),
      .MEM_rw_in     (MEM_rw_in),
      .MEM_addr_in   (MEM_addr_in),
      .MEM_data_in   (MEM_data_in),
      .MEM_len_in    (MEM_len_in),
      .IC_E_in       (IC_E_in),
      .IC_addr_in    (IC_addr_in),
      .mem_din_in    (mem_din_in),
      .busyICache_out(busyICache_out),
      .busyMEM_out   (busyMEM_out),
      .MEM_dataE_out (MEM_dataE_out),
      .MEM_data_out  (MEM_data_out),
      .IC_instE_out  (IC_instE_out),
      .IC_inst_out   (IC_inst_out),
      .mem_a_out     (mem_a_out),
      .mem_dout_out  (mem_dout_out),
      .mem_wr_out    (mem_wr_out)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- RAM model on the DUT's byte port ----------------
   logic [7:0] ram     [logic [AW-1:0]];
   logic [7:0] ref_mem [logic [AW-1:0]];

   function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5a;
   endfunction

   always @(posedge clk_in) begin
      if (mem_wr_out) ram[mem_a_out] = mem_dout_out;
      mem_din_in <= ram.exists(mem_a_out) ? ram[mem_a_out] : init_byte(mem_a_out);
   end

   function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
      return ram.exists(a) ? ram[a] : init_byte(a);
   endfunction

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   int            cyc;
   bit            m_active;
   int            m_t0;
   int            m_len;
   int            m_done;
   bit            m_write;
   bit            m_ic;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_word;

   // Called right after each rising edge that ends cycle 'cyc'.
   task automatic model_edge();
      int  k;
      bit  acc;
      if (m_active) begin
         k = cyc - m_t0;
         if (m_write && k >= 1 && k <= m_len)
            ref_mem[m_addr + 32'(k - 1)] = m_data[8*(k-1) +: 8];
         if (k == m_done)
            m_active = 1'b0;
         else if (m_ic && !IC_E_in)
            m_active = 1'b0;
      end else begin
         acc = 1'b0;
         if (MEM_E_in && MEM_len_in != 3'd0) begin
            acc     = 1'b1;
            m_ic    = 1'b0;
            m_write = MEM_rw_in;
            m_len   = (MEM_len_in > 3'd4) ? 4 : int'(MEM_len_in);
            m_addr  = MEM_addr_in;
            m_data  = MEM_data_in;
         end else if (IC_E_in) begin
            acc     = 1'b1;
            m_ic    = 1'b1;
            m_write = 1'b0;
            m_len   = 4;
            m_addr  = IC_addr_in;
            m_data  = '0;
         end
         if (acc) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_done   = m_write ? m_len + 1 : m_len + 2;
            m_word   = '0;
            if (!m_write)
               for (int i = 0; i < m_len; i++) m_word[8*i +: 8] = ref_rd(m_addr + 32'(i));
         end
      end
      cyc++;
   endtask

   task automatic compare_outputs();
      int            k;
      logic          e_bm, e_bi, e_me, e_ie, e_wr;
      logic [AW-1:0] e_a;
      logic [7:0]    e_d;
      e_bm = 1'b0; e_bi = 1'b0; e_me = 1'b0; e_ie = 1'b0; e_wr = 1'b0;
      e_a  = '0;   e_d  = '0;
      if (m_active) begin
         k = cyc - m_t0;
         if (m_ic) e_bi = 1'b1; else e_bm = 1'b1;
         if (k >= 1 && k <= m_len) begin
            e_a = m_addr + 32'(k - 1);
            if (m_write) begin
               e_d  = m_data[8*(k-1) +: 8];
               e_wr = 1'b1;
            end
         end
         if (k == m_done) begin
            if (m_ic) e_ie = 1'b1; else e_me = 1'b1;
         end
      end
      check("busyMEM",    32'(busyMEM_out),    32'(e_bm));
      check("busyICache", 32'(busyICache_out), 32'(e_bi));
      check("MEM_dataE",  32'(MEM_dataE_out),  32'(e_me));
      check("IC_instE",   32'(IC_instE_out),   32'(e_ie));
      check("mem_a",      mem_a_out,           e_a);
      check("mem_dout",   32'(mem_dout_out),   32'(e_d));
      check("mem_wr",     32'(mem_wr_out),     32'(e_wr));
      if (e_me) check("MEM_data", MEM_data_out, m_write ? 32'h0 : m_word);
      if (e_ie) check("IC_inst",  IC_inst_out,  m_word);
   endtask

   task automatic step();
      @(posedge clk_in);
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busyMEM"},  32'(busyMEM_out),    32'h0);
      check({tag, "_busyIC"},   32'(busyICache_out), 32'h0);
      check({tag, "_dataE"},    32'(MEM_dataE_out),  32'h0);
      check({tag, "_data"},     MEM_data_out,        32'h0);
      check({tag, "_instE"},    32'(IC_instE_out),   32'h0);
      check({tag, "_inst"},     IC_inst_out,         32'h0);
      check({tag, "_mem_a"},    mem_a_out,           32'h0);
      check({tag, "_mem_dout"}, 32'(mem_dout_out),   32'h0);
      check({tag, "_mem_wr"},   32'(mem_wr_out),     32'h0);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      ram[a]     = d;
      ref_mem[a] = d;
   endtask

   task automatic mem_req(input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [2:0] len);
      MEM_E_in    = 1'b1;
      MEM_rw_in   = rw;
      MEM_addr_in = a;
      MEM_data_in = d;
      MEM_len_in  = len;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      if ($urandom_range(0, 9) == 0) return 32'hffff_fffc + 32'($urandom_range(0, 3));
      return 32'($urandom_range(0, 63));
   endfunction

   initial begin
      cyc      = 0;
      m_active = 1'b0;
      m_t0     = 0;
      m_len    = 0;
      m_done   = 0;
      m_write  = 1'b0;
      m_ic     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      m_word   = '0;

      // Reset state
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;

      // LW 0x100, len 4
      preload(32'h100, 8'h11);
      preload(32'h101, 8'h22);
      preload(32'h102, 8'h33);
      preload(32'h103, 8'h44);
      mem_req(1'b0, 32'h100, 32'h0, 3'd4);
      step();                                  // cycle 1
      check("lw_addr_c1", mem_a_out, 32'h100);
      MEM_E_in = 1'b0;
      repeat (5) step();                       // cycle 6
      check("lw_pulse", 32'(MEM_dataE_out), 32'h1);
      check("lw_word",  MEM_data_out, 32'h4433_2211);
      step();                                  // cycle 7
      check("lw_busy_after", 32'(busyMEM_out), 32'h0);

      // SH 0x20, request held through DONE
      preload(32'h22, 8'h77);
      mem_req(1'b1, 32'h20, 32'hdead_beef, 3'd2);
      step();                                  // cycle 1
      check("sh_c1_dout", 32'(mem_dout_out), 32'hef);
      step();                                  // cycle 2
      check("sh_c2_addr", mem_a_out, 32'h21);
      check("sh_c2_dout", 32'(mem_dout_out), 32'hbe);
      step();                                  // cycle 3 (DONE)
      check("sh_pulse", 32'(MEM_dataE_out), 32'h1);
      step();                                  // cycle 4 idle, not restarted
      check("sh_no_restart", 32'(busyMEM_out), 32'h0);
      MEM_E_in = 1'b0;
      step();
      check("sh_ram20", 32'(ram_rd(32'h20)), 32'hef);
      check("sh_ram21", 32'(ram_rd(32'h21)), 32'hbe);
      check("sh_ram22", 32'(ram_rd(32'h22)), 32'h77);

      // Simultaneous MEM LB and I-cache fetch
      preload(32'h5, 8'h80);
      mem_req(1'b0, 32'h5, 32'h0, 3'd1);
      IC_E_in    = 1'b1;
      IC_addr_in = 32'h40;
      step();                                  // cycle 1
      check("sim_mem_first", 32'(busyMEM_out), 32'h1);
      MEM_E_in = 1'b0;
      repeat (2) step();                       // cycle 3
      check("sim_lb_pulse", 32'(MEM_dataE_out), 32'h1);
      check("sim_lb_word",  MEM_data_out, 32'h0000_0080);
      repeat (7) step();                       // cycle 10
      check("sim_ic_pulse", 32'(IC_instE_out), 32'h1);
      check("sim_ic_word",  IC_inst_out, 32'h1918_1b1a);
      IC_E_in = 1'b0;
      step();

      // I-cache abort
      IC_E_in    = 1'b1;
      IC_addr_in = 32'h0;
      repeat (2) step();                       // cycle 2
      IC_E_in = 1'b0;
      step();                                  // cycle 3
      check("abort_busy", 32'(busyICache_out), 32'h0);
      repeat (8) step();

      // Reset in the middle of a write
      mem_req(1'b1, 32'h200, 32'hcafe_f00d, 3'd4);
      step();                                  // cycle 1
      MEM_E_in = 1'b0;
      step();                                  // cycle 2
      #2 rst_in = 1'b0;
      #1;
      check_all_zero("midreset");
      m_active = 1'b0;
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b1;
      repeat (6) step();
      check("rst_ram200", 32'(ram_rd(32'h200)), 32'h0d);

      // Address wrap
      mem_req(1'b0, 32'hffff_fffe, 32'h0, 3'd4);
      step();                                  // cycle 1
      MEM_E_in = 1'b0;
      check("wrap_c1", mem_a_out, 32'hffff_fffe);
      repeat (2) step();                       // cycle 3
      check("wrap_c3", mem_a_out, 32'h0);
      step();                                  // cycle 4
      check("wrap_c4", mem_a_out, 32'h1);
      repeat (4) step();

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         MEM_E_in    = ($urandom_range(0, 3) == 0);
         MEM_rw_in   = 1'($urandom_range(0, 1));
         MEM_len_in  = 3'($urandom_range(0, 7));
         MEM_addr_in = pick_addr();
         MEM_data_in = $urandom();
         IC_E_in     = ($urandom_range(0, 11) != 0);
         IC_addr_in  = pick_addr();
         step();
      end
      MEM_E_in = 1'b0;
      IC_E_in  = 1'b0;
      repeat (10) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
- Memory controller directly downstream of the MEM stage and the I-cache.
- Arbitrates between data requests from MEM and instruction fetches from the I-cache.
- Serialises each access onto the byte-wide synchronous RAM port.
- Returns assembled little-endian words with a one-cycle completion pulse per requester.

Parameters:
ADDR_WIDTH, 32, width of request and RAM addresses
DATA_WIDTH, 32, width of assembled data/instruction words

Ports:
clk_in  input  1  system clock, all state updates on rising edge
rst_in  input  1  asynchronous, active-low reset
MEM_E_in  input  1  MEM requests an access
MEM_rw_in  input  1  0=READ, 1=WRITE
MEM_addr_in  input  ADDR_WIDTH  byte address of first byte
MEM_data_in  input  DATA_WIDTH  store data, byte0 = bits[7:0]
MEM_len_in  input  3  byte count (1, 2, 4)
IC_E_in  input  1  I-cache fetch request (always 4 bytes)
IC_addr_in  input  ADDR_WIDTH  fetch address
mem_din_in  input  8  RAM read byte, valid one cycle after address
busyICache_out  output  1  controller currently owned by the I-cache
busyMEM_out  output  1  controller currently owned by MEM
MEM_dataE_out  output  1  one-cycle MEM completion pulse
MEM_data_out  output  DATA_WIDTH  zero-extended load data, valid with MEM_dataE_out
IC_instE_out  output  1  one-cycle fetch completion pulse
IC_inst_out  output  DATA_WIDTH  fetched instruction, valid with IC_instE_out
mem_a_out  output  ADDR_WIDTH  RAM address
mem_dout_out  output  8  RAM write byte
mem_wr_out  output  1  RAM write enable

Behaviour:
- Reset: one clock, clk_in; reset is asynchronous and active-low (rst_in=0). All outputs are 0 immediately on reset. State = IDLE, counters = 0. Reset mid-transaction aborts it with no completion pulse.
- Registering: all outputs are registered; there is no combinational input-to-output path.
- States:
  - IDLE: accepts a request.
  - READ: issues byte addresses and captures returned bytes.
  - WRITE: issues address/data bytes.
  - DONE: drives the completion pulse.
- IDLE arbitration, sampled at a rising edge:
  - MEM_E_in=1 with len≠0 wins over IC_E_in.
  - Otherwise IC_E_in=1 is accepted.
  - Effective length: len 0 = no request; len>4 saturates to 4.
  - Request fields (addr, data, len, rw, owner) are latched at acceptance; later input changes are ignored, except the I-cache abort rule below.
- Owner flags: busyMEM_out / busyICache_out are 1 from the cycle after acceptance through the DONE cycle inclusive.
- Read of L bytes, accepted at the end of cycle 0:
  - Cycles 1..L: mem_a_out = A+j-1, mem_wr_out = 0.
  - Byte j-1 is captured at the end of cycle j+1.
  - Cycle L+2 is DONE: the owner's E pulse and word are driven; unread upper bytes are 0.
- Write of L bytes (MEM only):
  - Cycles 1..L: mem_a_out = A+j-1, mem_dout_out = byte j-1, mem_wr_out = 1.
  - Cycle L+1 is DONE with MEM_dataE_out = 1; MEM_data_out = 0.
- Outside active cycles: mem_a_out = 0, mem_dout_out = 0, mem_wr_out = 0.
- Address arithmetic: ADDR_WIDTH modulo (wraps at all-ones).
- DONE:
  - Exactly one cycle, then IDLE.
  - No request is accepted in DONE, so MEM's still-asserted request is never restarted.
- I-cache abort: if IC_E_in=0 at a rising edge while the I-cache owns READ:
  - Return to IDLE next cycle.
  - No IC_instE_out pulse; busyICache_out drops.
- MEM transactions are never aborted.
- Back-to-back: a new request can be accepted at the end of the first IDLE cycle after DONE.

Decomposition:
- Shared defines.vh additions: state encodings (IDLE/READ/WRITE/DONE), READ/WRITE, Busy/Enable, and the active-low reset level constant.
- Single module. The byte-assembly/extraction logic is small and stays inline; no sub-module is warranted.

Test Plan:
- LW: MEM_E_in=1, rw=0, addr=0x100, len=4; RAM holds 0x11,0x22,0x33,0x44 at 0x100..0x103 -> mem_a_out 0x100..0x103 in cycles 1-4; cycle 6: MEM_dataE_out=1, MEM_data_out=0x44332211; busyMEM_out=1 cycles 1-6.
- SH: rw=1, addr=0x20, data=0xDEADBEEF, len=2 -> cycles 1-2: (0x20, 0xEF, wr=1), (0x21, 0xBE, wr=1); cycle 3: MEM_dataE_out=1; RAM 0x22 untouched.
- Simultaneous: MEM_E_in and IC_E_in both 1 in IDLE -> MEM served first (LB addr 0x5, byte 0x80 -> MEM_data_out=0x00000080 at cycle 3); fetch accepted at end of cycle 4; IC_instE_out at cycle 10.
- I-cache abort: fetch at 0x0 accepted, IC_E_in dropped in cycle 2 -> IDLE in cycle 3, no IC_instE_out, busyICache_out=0 from cycle 3.
- Reset: rst_in=0 mid-write in cycle 2 -> mem_wr_out=0 and all outputs 0 immediately (before next clock edge); after release, controller is IDLE and no dataE pulse occurs.
- Wrap: LW at addr 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
